// File: rtl/mips_pkg.sv
// Shared MIPS encoding definitions: mnemonics, opcode/funct constants,
// instruction format classes and the mnemonic-to-format mapping.
package mips_pkg;

    typedef enum logic [3:0] {
        NEM_ZERO  = 4'd0,
        NEM_ADD   = 4'd1,
        NEM_AND   = 4'd2,
        NEM_OR    = 4'd3,
        NEM_SLT   = 4'd4,
        NEM_SUB   = 4'd5,
        NEM_XOR   = 4'd6,
        NEM_ADDI  = 4'd7,
        NEM_ADDIU = 4'd8,
        NEM_LW    = 4'd9,
        NEM_SW    = 4'd10,
        NEM_BEQ   = 4'd11,
        NEM_ABS   = 4'd12,
        NEM_JUMP  = 4'd13
    } t_instr_pnmen;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_J,
        FMT_NOP,
        FMT_BAD
    } t_instr_fmt;

    // Primary opcodes; ABS sits in an otherwise unused opcode slot.
    localparam logic [5:0] ZERO  = 6'h00;
    localparam logic [5:0] ADDI  = 6'h08;
    localparam logic [5:0] ADDIU = 6'h09;
    localparam logic [5:0] BEQ   = 6'h04;
    localparam logic [5:0] LW    = 6'h23;
    localparam logic [5:0] SW    = 6'h2B;
    localparam logic [5:0] JUMP  = 6'h02;
    localparam logic [5:0] ABS   = 6'h1C;

    // R-type funct codes
    localparam logic [5:0] ADD   = 6'h20;
    localparam logic [5:0] AND   = 6'h24;
    localparam logic [5:0] OR    = 6'h25;
    localparam logic [5:0] SLT   = 6'h2A;
    localparam logic [5:0] SUB   = 6'h22;
    localparam logic [5:0] XOR   = 6'h26;

    typedef struct packed {
        logic        last;
        logic [31:0] word;
    } t_fifo_ent;

    function automatic t_instr_fmt nem_to_fmt(input t_instr_pnmen nem);
        t_instr_fmt fmt;
        case (nem)
            NEM_ADD, NEM_AND, NEM_OR, NEM_SLT, NEM_SUB, NEM_XOR:
                fmt = FMT_R;
            NEM_ADDI, NEM_ADDIU, NEM_LW, NEM_SW, NEM_BEQ, NEM_ABS:
                fmt = FMT_I;
            NEM_JUMP:
                fmt = FMT_J;
            NEM_ZERO:
                fmt = FMT_NOP;
            default:
                fmt = FMT_BAD;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/mips_instr_encoder_fifo.sv
// Two-entry FIFO of {last, word}. The tail entry's last bit can be set in
// place so an end-of-program marker can be attached after the word was queued.
module enc_fifo2
    import mips_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      i_push_valid,
    output logic      o_push_ready,
    input  t_fifo_ent i_push_data,
    input  logic      i_mark_tail,
    output logic      o_pop_valid,
    input  logic      i_pop_ready,
    output t_fifo_ent o_pop_data,
    output logic [1:0] o_count
);

    t_fifo_ent  r_mem [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;
    logic       w_push;
    logic       w_pop;

    assign o_push_ready = (r_count != 2'd2);
    assign o_pop_valid  = (r_count != 2'd0);
    assign o_pop_data   = r_mem[r_rd_ptr];
    assign o_count      = r_count;
    assign w_push       = i_push_valid && o_push_ready;
    assign w_pop        = o_pop_valid && i_pop_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            for (int unsigned i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= !r_wr_ptr;
            end
            // Tail is the most recently written slot, one behind the write pointer.
            if (i_mark_tail && !w_push) begin
                r_mem[!r_wr_ptr].last <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= !r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mips_instr_encoder.sv
// Streaming MIPS instruction encoder: packs mnemonic + fields into 32-bit
// words, buffers them two deep and emits them with sequential byte addresses.
module mips_instr_encoder
    import mips_pkg::*;
#(
    parameter int unsigned        ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  t_instr_pnmen      in_nem,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic              done,
    output logic              err
);

    t_instr_fmt        w_fmt;
    logic [5:0]        w_opc;
    logic [5:0]        w_funct;
    logic [31:0]       w_word;
    logic              w_accept;
    logic              w_bad;
    logic              w_push;
    logic              w_pop;
    logic              w_direct;
    logic              w_mark_tail;
    logic              w_fifo_ready;
    logic              w_fifo_valid;
    logic [1:0]        w_count;
    t_fifo_ent         w_head;
    logic              r_done;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;

    always_comb begin
        w_fmt   = nem_to_fmt(in_nem);
        w_opc   = ZERO;
        w_funct = ZERO;
        case (in_nem)
            NEM_ADD:   w_funct = ADD;
            NEM_AND:   w_funct = AND;
            NEM_OR:    w_funct = OR;
            NEM_SLT:   w_funct = SLT;
            NEM_SUB:   w_funct = SUB;
            NEM_XOR:   w_funct = XOR;
            NEM_ADDI:  w_opc   = ADDI;
            NEM_ADDIU: w_opc   = ADDIU;
            NEM_LW:    w_opc   = LW;
            NEM_SW:    w_opc   = SW;
            NEM_BEQ:   w_opc   = BEQ;
            NEM_ABS:   w_opc   = ABS;
            NEM_JUMP:  w_opc   = JUMP;
            default:   w_opc   = ZERO;
        endcase

        w_word = '0;
        case (w_fmt)
            FMT_R:   w_word = {ZERO, in_rs, in_rt, in_rd, 5'b0, w_funct};
            FMT_I:   w_word = {w_opc, in_rs, in_rt, (in_nem == NEM_ABS) ? 16'h0000 : in_imm};
            FMT_J:   w_word = {w_opc, in_target};
            default: w_word = '0;
        endcase
    end

    assign in_ready = w_fifo_ready;
    assign w_accept = in_valid && w_fifo_ready;
    assign w_bad    = w_accept && (w_fmt == FMT_BAD);
    assign w_push   = w_accept && (w_fmt != FMT_BAD);
    assign w_pop    = w_fifo_valid && out_ready;

    // An illegal beat carrying in_last ends the program: if nothing will be
    // left queued after this edge, finish now; otherwise tag the newest word.
    assign w_direct    = w_bad && in_last &&
                         ((w_count == 2'd0) || ((w_count == 2'd1) && w_pop));
    assign w_mark_tail = w_bad && in_last && !w_direct;

    enc_fifo2 u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push_valid (w_push),
        .o_push_ready (w_fifo_ready),
        .i_push_data  ({in_last, w_word}),
        .i_mark_tail  (w_mark_tail),
        .o_pop_valid  (w_fifo_valid),
        .i_pop_ready  (out_ready),
        .o_pop_data   (w_head),
        .o_count      (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= BASE_ADDR;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= (w_pop && w_head.last) || w_direct;
            if (w_bad) begin
                r_err <= 1'b1;
            end
            if ((w_pop && w_head.last) || w_direct) begin
                r_addr <= BASE_ADDR;
            end else if (w_pop) begin
                r_addr <= r_addr + ADDR_W'(4);
            end
        end
    end

    assign out_valid = w_fifo_valid;
    assign out_word  = w_head.word;
    assign out_addr  = r_addr;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Scoreboard bench for mips_instr_encoder: directed program scenarios plus
// randomized instruction streams against an arithmetic reference encoder.
`timescale 1ns/1ps
module tb_mips_instr_encoder;
    import mips_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_0400;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    t_instr_pnmen in_nem;
    logic [4:0]   in_rs, in_rt, in_rd;
    logic [15:0]  in_imm;
    logic [25:0]  in_target;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_word;
    logic [31:0]  out_addr;
    logic         done;
    logic         err;

    always #5 clk = ~clk;

    mips_instr_encoder #(.ADDR_W(32), .BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_nem    (in_nem),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_imm    (in_imm),
        .in_target (in_target),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_addr  (out_addr),
        .done      (done),
        .err       (err)
    );

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] addr;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_addr;
    logic        exp_err;
    logic        bad_last_pend;
    logic        exp_done;
    int          ready_mode;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // MIPS field layout: op[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] funct[5:0]
    function automatic logic [31:0] ref_enc(input t_instr_pnmen n,
                                            input int unsigned rs, input int unsigned rt,
                                            input int unsigned rd, input int unsigned imm,
                                            input int unsigned tgt, output bit legal);
        longint unsigned w;
        longint unsigned op;
        longint unsigned fn;
        byte kind;
        op = 0; fn = 0; legal = 1'b1;
        case (n)
            NEM_ADD:   begin kind = "R"; fn = 32; end
            NEM_AND:   begin kind = "R"; fn = 36; end
            NEM_OR:    begin kind = "R"; fn = 37; end
            NEM_SLT:   begin kind = "R"; fn = 42; end
            NEM_SUB:   begin kind = "R"; fn = 34; end
            NEM_XOR:   begin kind = "R"; fn = 38; end
            NEM_ADDI:  begin kind = "I"; op = 8;  end
            NEM_ADDIU: begin kind = "I"; op = 9;  end
            NEM_LW:    begin kind = "I"; op = 35; end
            NEM_SW:    begin kind = "I"; op = 43; end
            NEM_BEQ:   begin kind = "I"; op = 4;  end
            NEM_ABS:   begin kind = "A"; op = 28; end
            NEM_JUMP:  begin kind = "J"; op = 2;  end
            NEM_ZERO:  kind = "N";
            default:   begin kind = "X"; legal = 1'b0; end
        endcase
        w = 0;
        if (kind == "R") w = rs * 64'd2097152 + rt * 64'd65536 + rd * 64'd2048 + fn;
        if (kind == "I") w = op * 64'd67108864 + rs * 64'd2097152 + rt * 64'd65536 + imm;
        if (kind == "A") w = op * 64'd67108864 + rs * 64'd2097152 + rt * 64'd65536;
        if (kind == "J") w = op * 64'd67108864 + tgt;
        return w[31:0];
    endfunction

    task automatic send(input t_instr_pnmen n, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                        input logic last);
        bit          acc;
        bit          legal;
        logic [31:0] w;
        exp_t        e;
        in_valid = 1'b1; in_nem = n; in_rs = rs; in_rt = rt; in_rd = rd;
        in_imm = imm; in_target = tgt; in_last = last;
        acc = 1'b0;
        for (int c = 0; c < 300 && !acc; c++) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
        end
        if (!acc) begin
            check("accept_timeout", in_ready, 1);
        end else begin
            #1;
            w = ref_enc(n, rs, rt, rd, imm, tgt, legal);
            if (legal) begin
                sb.push_back('{word: w, addr: exp_addr, last: last});
                exp_addr = last ? BASE : exp_addr + 32'd4;
            end else begin
                exp_err = 1'b1;
                if (last) begin
                    if (sb.size() == 0) begin
                        bad_last_pend = 1'b1;
                    end else begin
                        e = sb[sb.size()-1];
                        e.last = 1'b1;
                        sb[sb.size()-1] = e;
                    end
                    exp_addr = BASE;
                end
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 400 && sb.size() != 0; c++) @(posedge clk);
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // out_ready driver: 0 = always ready, 1 = stalled, else random
    initial forever begin
        @(posedge clk); #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    // Monitor: checks flags every cycle, compares each popped word to the scoreboard head.
    initial begin
        exp_t        e;
        logic        hold_v;
        logic [31:0] hold_w, hold_a;
        hold_v = 1'b0; hold_w = '0; hold_a = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_v   = 1'b0;
                exp_done = 1'b0;
            end else begin
                check("done", done, exp_done | bad_last_pend);
                bad_last_pend = 1'b0;
                exp_done      = 1'b0;
                check("err", err, exp_err);
                check("in_ready", in_ready, sb.size() < 2);
                check("out_valid", out_valid, sb.size() > 0);
                if (hold_v && out_valid) begin
                    check("hold_word", out_word, hold_w);
                    check("hold_addr", out_addr, hold_a);
                end
                hold_v = out_valid && !out_ready;
                hold_w = out_word;
                hold_a = out_addr;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_pop", out_valid, 0);
                    end else begin
                        e = sb.pop_front();
                        check("word", out_word, e.word);
                        check("addr", out_addr, e.addr);
                        exp_done = e.last;
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_nem = NEM_ZERO; in_rs = '0; in_rt = '0; in_rd = '0;
        in_imm = '0; in_target = '0; in_last = 1'b0; out_ready = 1'b0; ready_mode = 0;
        exp_addr = BASE; exp_err = 1'b0; bad_last_pend = 1'b0; exp_done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_word", out_word, 0);
        check("rst_out_addr", out_addr, BASE);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        send(NEM_ADD, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
        send(NEM_LW, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0, 1'b0);
        send(NEM_BEQ, 5'd8, 5'd0, 5'd0, 16'hFFFE, 26'h0, 1'b0);
        send(NEM_JUMP, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000010, 1'b1);
        send(NEM_ADD, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b0);
        drain();

        // Backpressure: two fill the FIFO, third waits until consumer releases.
        ready_mode = 1;
        send(NEM_SW, 5'd3, 5'd4, 5'd0, 16'h0010, 26'h0, 1'b0);
        send(NEM_ADDIU, 5'd7, 5'd9, 5'd0, 16'h8000, 26'h0, 1'b0);
        fork
            send(NEM_XOR, 5'd10, 5'd11, 5'd12, 16'h0, 26'h0, 1'b0);
            begin repeat (6) @(posedge clk); ready_mode = 0; end
        join
        drain();

        // Illegal mnemonic between two ADDI; then an illegal end-of-program on empty FIFO.
        send(NEM_ADDI, 5'd1, 5'd2, 5'd0, 16'h0007, 26'h0, 1'b0);
        send(t_instr_pnmen'(4'd14), 5'd1, 5'd2, 5'd3, 16'h1234, 26'h0, 1'b0);
        send(NEM_ADDI, 5'd2, 5'd3, 5'd0, 16'hFFFF, 26'h0, 1'b0);
        drain();
        send(t_instr_pnmen'(4'd15), 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1);
        send(NEM_ABS, 5'd6, 5'd7, 5'd0, 16'hABCD, 26'h0, 1'b0);
        drain();

        // Reset with two words buffered discards them and clears err.
        ready_mode = 1;
        send(NEM_OR, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 1'b0);
        send(NEM_SUB, 5'd2, 5'd2, 5'd2, 16'h0, 26'h0, 1'b0);
        rst = 1'b1;
        sb.delete();
        exp_addr = BASE; exp_err = 1'b0; bad_last_pend = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        ready_mode = 0;
        @(negedge clk);
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_addr", out_addr, BASE);
        check("post_rst_err", err, 0);
        @(posedge clk); #1;

        // Randomized stream with random consumer stalls.
        ready_mode = 2;
        for (int i = 0; i < 300; i++) begin
            logic [3:0] nv;
            nv = 4'($urandom_range(0, 15));
            send(t_instr_pnmen'(nv), 5'($urandom), 5'($urandom), 5'($urandom),
                 16'($urandom), 26'($urandom), ($urandom_range(0, 7) == 0));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
Streaming MIPS instruction encoder, the inverse of the control decoder. It accepts one instruction per handshake as a t_instr_pnmen mnemonic plus register and immediate fields, and packs it into a 32-bit MIPS word. Encoded words are buffered in a 2-entry output FIFO and presented with a word address, so a bench or boot loader can fill instruction memory.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first emitted word
ADDR_W, 32, width of out_addr

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
in_valid  in  1  instruction fields valid
in_ready  out  1  encoder can accept (FIFO not full)
in_nem  in  t_instr_pnmen  mnemonic
in_rs  in  5  source register
in_rt  in  5  second source / I-type destination
in_rd  in  5  R-type destination
in_imm  in  16  immediate / branch word offset
in_target  in  26  jump target (word index)
in_last  in  1  marks final instruction of a program
out_valid  out  1  encoded word available
out_ready  in  1  consumer accepts word
out_word  out  32  encoded instruction
out_addr  out  ADDR_W  byte address of out_word
done  out  1  one-cycle pulse when last word is consumed
err  out  1  sticky: illegal mnemonic received

Behaviour:
- Reset (synchronous, active-high): FIFO empty, out_valid=0, in_ready=1, out_word=0, out_addr=BASE_ADDR, done=0, err=0. Reset mid-transfer discards all buffered words.
- Accept on in_valid&&in_ready. in_ready = !full (FIFO count<2). It is not combinationally dependent on out_ready.
- Encode stage is registered. An accepted word enters the FIFO at the next edge, and out_valid rises 1 cycle after acceptance when the FIFO was empty.
- Formats:
  - R-type (NEM_ADD/AND/OR/SLT/SUB/XOR): {ZERO, rs, rt, rd, 5'b0, funct}, funct from the package constant.
  - I-type (NEM_ADDI/ADDIU/LW/SW/BEQ): {opcode, rs, rt, imm}. imm is passed unmodified; BEQ imm is the signed word offset.
  - NEM_ABS: {ABS, rs, rt, 16'b0}.
  - NEM_JUMP: {JUMP, target}.
  - NEM_ZERO: 32'h0 (NOP).
- Any other mnemonic encoding: handshake still completes, nothing is pushed, err sets and holds until rst. If in_last is set on such a beat, the last flag is still recorded so done fires on the next emitted word, or immediately in the following cycle if the FIFO is empty.
- Pop on out_valid&&out_ready. out_addr advances by 4 after each pop. out_addr is held while out_valid&&!out_ready; word and address are stable under backpressure.
- Simultaneous push and pop with the FIFO full: the pop frees space, but in_ready was low, so no push occurs that cycle. With count=1, a simultaneous push and pop keeps count=1.
- The last flag is stored per FIFO entry. When an entry with last=1 pops, done=1 for exactly that cycle+1 (registered), and out_addr reloads BASE_ADDR for the next program.
- out_addr wraps modulo 2^ADDR_W.
- Out-of-range register fields cannot occur (5-bit ports). Unused fields (rd for I-type, rs/rt for J) are ignored.

Decomposition:
- mips_pkg holds t_instr_pnmen, the opcode and funct constants (ZERO, ADDI, ADDIU, BEQ, LW, SW, JUMP, ABS, ADD, AND, OR, SLT, SUB, XOR), and a new t_instr_fmt enum {FMT_R, FMT_I, FMT_J, FMT_NOP, FMT_BAD}.
- A pure function nem_to_fmt also lives in the package, shared with the decoder checker.
- One sub-module, enc_fifo2: 2-entry FIFO of {last, word[31:0]} with valid/ready on both sides.

Test Plan:
- NEM_ADD rs=1 rt=2 rd=3 with out_ready=1 -> out_word=32'h0022_1820, out_addr=0, out_valid 1 cycle after accept.
- NEM_LW rs=29 rt=8 imm=16'h0004, then NEM_BEQ rs=8 rt=0 imm=16'hFFFE -> words 32'h8FA8_0004 and 32'h1100_FFFE at addr 0 and 4.
- NEM_JUMP target=26'h0000010, in_last=1 -> 32'h0800_0010; done pulses once after the pop; next word's out_addr=BASE_ADDR.
- Hold out_ready=0, push 3 instrs -> in_ready drops after 2 accepted, out_word/out_addr stable; release -> words emitted in order, addresses 0, 4, then the third accepted.
- Illegal mnemonic between two ADDI -> err=1 sticky, only two words emitted at addr 0, 4; rst clears err.
- Assert rst with 2 words buffered -> next cycle out_valid=0, in_ready=1, out_addr=BASE_ADDR.
